mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be:
- AW, default 32, address width.
- DW, default 32, data width.

REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  instruction fetch request.
- if_addr  in  AW  fetch byte address.
- if_rdata  out  DW  fetch data, valid when if_req=1 and if_stall=0.
- if_stall  out  1  holds the fetch stage (PC/IF_ID write disable).
- d_read  in  1  data load request (MEM stage MemRead).
- d_write  in  1  data store request (MEM stage MemWrite).
- d_addr  in  AW  data byte address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load data, valid when d_read=1 and d_stall=0.
- d_stall  out  1  freezes the whole pipeline.
- mem_req  out  1  shared memory access strobe.
- mem_we  out  1  write enable for the current access.
- mem_addr  out  AW  access address.
- mem_wdata  out  DW  write data.
- mem_rdata  in  DW  memory read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse from memory, latency >=1 cycle.

Function
REQ-003 FSM states SHALL be IDLE, IF_BUSY and D_BUSY.
REQ-004 In IDLE, the arbiter SHALL grant as follows:
- Data request pending (d_read|d_write): go to D_BUSY.
- Else if_req=1: go to IF_BUSY.
- Else stay in IDLE.
REQ-005 On grant, the arbiter SHALL register mem_addr, mem_we and mem_wdata from the winner.
- mem_we=d_write for a data grant, 0 for a fetch grant.
- Values SHALL stay stable until mem_ack.
REQ-006 mem_req SHALL be 1 exactly in IF_BUSY and D_BUSY and 0 in IDLE.
REQ-007 In a BUSY state with mem_ack=1, the FSM SHALL return to IDLE on the next edge; no back-to-back grant in the ack cycle.
REQ-008 mem_ack received in IDLE SHALL be ignored.
REQ-009 if_stall SHALL equal if_req AND NOT (state==IF_BUSY AND mem_ack), combinationally.
REQ-010 d_stall SHALL equal (d_read|d_write) AND NOT (state==D_BUSY AND mem_ack), combinationally.
REQ-011 if_rdata and d_rdata SHALL both pass mem_rdata combinationally.
REQ-012 d_stall SHALL also be asserted whenever if_stall is asserted, so the pipeline never advances with a fetch outstanding.
REQ-013 If d_read and d_write are both 1, the access SHALL be a write.
REQ-014 A granted access SHALL complete even if its request drops (for example, a fetch flush).
- Ack data for a dropped request is discarded.
- No stall is produced for the dropped request.
REQ-015 Every access SHALL take at least 2 cycles: grant edge, then ack cycle.

Reset
REQ-016 While rst=1, the arbiter SHALL set:
- State = IDLE.
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- The fairness flag = 0.
REQ-017 Reset during a BUSY state SHALL abandon the access.
- mem_req falls on that edge.
- A later mem_ack is ignored per REQ-008.
REQ-018 During reset, stall outputs SHALL follow REQ-009/REQ-010 with state = IDLE.

Configuration
REQ-019 With macro MEM_ARB_FAIR_EN defined, the arbiter SHALL keep a 1-bit flag set on each data grant and cleared on each fetch grant.
- In IDLE with both requests pending and the flag set, the fetch SHALL win.
REQ-020 Without MEM_ARB_FAIR_EN, data SHALL always have fixed priority over fetch, and no flag register SHALL exist.

Verification
REQ-021 Fetch only:
- Stimulus: if_req=1, if_addr=0x40, memory acks 2 cycles after mem_req, mem_rdata=0x8C010004.
- Response: mem_req high for 2 cycles; if_stall low only in the ack cycle; if_rdata=0x8C010004.
REQ-022 Simultaneous requests:
- Stimulus: if_req=1 (0x44) and d_read=1 (0x100) in IDLE.
- Response without macro: data access is issued first, then fetch; both stalls high until the data ack.
- Response with MEM_ARB_FAIR_EN and flag=1: fetch is issued first.
REQ-023 Store:
- Stimulus: d_write=1, d_addr=0x200, d_wdata=0xDEADBEEF.
- Response: mem_we=1, mem_addr=0x200, mem_wdata=0xDEADBEEF, all held until ack; d_stall falls in the ack cycle.
REQ-024 Flush:
- Stimulus: if_req drops while in IF_BUSY.
- Response: mem_req stays high until ack, then IDLE; no stall asserted.
REQ-025 Reset mid-access:
- Stimulus: rst=1 for 1 cycle in D_BUSY, followed by a stray mem_ack.
- Response: IDLE, mem_req=0, mem_addr=0; stray ack produces no state change.
REQ-026 Read/write conflict:
- Stimulus: d_read=1 and d_write=1 together.
- Response: mem_we=1.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared-memory arbiter between the instruction fetch port and the data port.
// Define MEM_ARB_FAIR_EN to make fetch and data alternate when they collide.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    input  logic          d_read,
    input  logic          d_write,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic d_req;
    logic d_wins;
    logic grant_d;
    logic grant_if;
    logic if_done;
    logic d_done;

    assign d_req = d_read | d_write;

`ifdef MEM_ARB_FAIR_EN
    logic fair_flag;

    // Last grant went to data: let a colliding fetch go first this time.
    assign d_wins = d_req & ~(if_req & fair_flag);

    always_ff @(posedge clk) begin
        if (rst) begin
            fair_flag <= 1'b0;
        end else if (grant_d) begin
            fair_flag <= 1'b1;
        end else if (grant_if) begin
            fair_flag <= 1'b0;
        end
    end
`else
    assign d_wins = d_req;
`endif

    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_if  = 1'b0;
        unique case (state)
            IDLE: begin
                if (d_wins) begin
                    state_nxt = D_BUSY;
                    grant_d   = 1'b1;
                end else if (if_req) begin
                    state_nxt = IF_BUSY;
                    grant_if  = 1'b1;
                end
            end
            IF_BUSY, D_BUSY: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (grant_d) begin
                mem_we    <= d_write;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (grant_if) begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end
        end
    end

    // Completion is seen as idle while reset is held, so stalls track requests.
    assign if_done = (state == IF_BUSY) & mem_ack & ~rst;
    assign d_done  = (state == D_BUSY) & mem_ack & ~rst;

    assign mem_req  = (state != IDLE);
    assign if_stall = if_req & ~if_done;
    assign d_stall  = (d_req & ~d_done) | if_stall;
    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with an access scoreboard.
// Expected memory accesses are queued at request time and checked at grant.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_stall;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    acc_t sb[$];
    acc_t cur;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_stall  (if_stall),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_stall   (d_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_stalls(input string tag, input logic e_if,
                              input logic e_d);
        chk({tag, "_if_stall"}, 32'(if_stall), 32'(e_if));
        chk({tag, "_d_stall"}, 32'(d_stall), 32'(e_d));
    endtask

    task automatic chk_bus(input string tag);
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_we"}, 32'(mem_we), 32'(cur.we));
        chk({tag, "_addr"}, mem_addr, cur.addr);
        chk({tag, "_wdata"}, mem_wdata, cur.wdata);
    endtask

    // Called at posedge+1 with requests driven and the arbiter idle.
    task automatic grant(input string tag, input logic e_if, input logic e_d);
        @(negedge clk);
        chk({tag, "_idle_req"}, 32'(mem_req), 32'd0);
        chk_stalls({tag, "_idle"}, e_if, e_d);
        @(posedge clk);
        #1;
        @(negedge clk);
        n_chk++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s_sb_empty observed=0 expected=1", tag);
        end
        if (sb.size() != 0) cur = sb.pop_front();
        chk_bus({tag, "_grant"});
        chk_stalls({tag, "_busy"}, e_if, e_d);
    endtask

    // Ack arrives lat cycles after mem_req rose; returns in the ack cycle.
    task automatic ack(input string tag, input int lat, input logic [DW-1:0] rd,
                       input logic e_if, input logic e_d);
        for (int i = 1; i < lat; i++) begin
            @(posedge clk);
            #1;
            if (i == lat - 1) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end
            @(negedge clk);
            chk_bus({tag, "_hold"});
            if (i < lat - 1) chk_stalls({tag, "_wait"}, e_if, e_d);
        end
    endtask

    task automatic ack_done();
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk_stalls("rst", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fetch only
        if_req  = 1'b1;
        if_addr = 32'h40;
        sb.push_back('{1'b0, 32'h40, 32'h0});
        grant("fetch", 1'b1, 1'b1);
        ack("fetch", 2, 32'h8C010004, 1'b1, 1'b1);
        chk_stalls("fetch_ack", 1'b0, 1'b0);
        chk("fetch_rdata", if_rdata, 32'h8C010004);
        ack_done();
        if_req = 1'b0;
        @(negedge clk);
        chk("fetch_end_req", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1;

        // Store held over a longer latency
        d_write = 1'b1;
        d_addr  = 32'h200;
        d_wdata = 32'hDEADBEEF;
        sb.push_back('{1'b1, 32'h200, 32'hDEADBEEF});
        grant("store", 1'b0, 1'b1);
        ack("store", 3, 32'h0, 1'b0, 1'b1);
        chk_stalls("store_ack", 1'b0, 1'b0);
        ack_done();
        d_write = 1'b0;
        d_wdata = '0;

        // Simultaneous fetch and load
        if_req  = 1'b1;
        if_addr = 32'h44;
        d_read  = 1'b1;
        d_addr  = 32'h100;
`ifdef MEM_ARB_FAIR_EN
        sb.push_back('{1'b0, 32'h44, 32'h0});
        sb.push_back('{1'b0, 32'h100, 32'h0});
        grant("sim_f", 1'b1, 1'b1);
        ack("sim_f", 2, 32'h22222222, 1'b1, 1'b1);
        chk("sim_f_rdata", if_rdata, 32'h22222222);
        chk_stalls("sim_f_ack", 1'b0, 1'b1);
        ack_done();
        if_req = 1'b0;
        grant("sim_d", 1'b0, 1'b1);
        ack("sim_d", 2, 32'h11111111, 1'b0, 1'b1);
        chk("sim_d_rdata", d_rdata, 32'h11111111);
        chk_stalls("sim_d_ack", 1'b0, 1'b0);
        ack_done();
        d_read = 1'b0;
`else
        sb.push_back('{1'b0, 32'h100, 32'h0});
        sb.push_back('{1'b0, 32'h44, 32'h0});
        grant("sim_d", 1'b1, 1'b1);
        ack("sim_d", 2, 32'h11111111, 1'b1, 1'b1);
        chk("sim_d_rdata", d_rdata, 32'h11111111);
        chk_stalls("sim_d_ack", 1'b1, 1'b1);
        ack_done();
        d_read = 1'b0;
        grant("sim_f", 1'b1, 1'b1);
        ack("sim_f", 2, 32'h22222222, 1'b1, 1'b1);
        chk("sim_f_rdata", if_rdata, 32'h22222222);
        chk_stalls("sim_f_ack", 1'b0, 1'b0);
        ack_done();
        if_req = 1'b0;
`endif

        // Flushed fetch still completes
        if_req  = 1'b1;
        if_addr = 32'h80;
        sb.push_back('{1'b0, 32'h80, 32'h0});
        grant("flush", 1'b1, 1'b1);
        if_req = 1'b0;
        #1;
        chk_stalls("flush_drop", 1'b0, 1'b0);
        ack("flush", 3, 32'h33333333, 1'b0, 1'b0);
        chk_stalls("flush_ack", 1'b0, 1'b0);
        ack_done();
        @(negedge clk);
        chk("flush_end_req", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1;

        // Read and write together behaves as a write
        d_read  = 1'b1;
        d_write = 1'b1;
        d_addr  = 32'h204;
        d_wdata = 32'h12345678;
        sb.push_back('{1'b1, 32'h204, 32'h12345678});
        grant("rw", 1'b0, 1'b1);
        ack("rw", 2, 32'h0, 1'b0, 1'b1);
        chk_stalls("rw_ack", 1'b0, 1'b0);
        ack_done();
        d_read  = 1'b0;
        d_write = 1'b0;
        d_wdata = '0;

        // Reset while the data access is outstanding
        d_read = 1'b1;
        d_addr = 32'h300;
        sb.push_back('{1'b0, 32'h300, 32'h0});
        grant("rstmid", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        chk_stalls("rstmid_inrst", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        mem_ack = 1'b0;
        d_read  = 1'b0;
        @(negedge clk);
        chk("rstmid_req", 32'(mem_req), 32'd0);
        chk("rstmid_addr", mem_addr, 32'd0);
        chk("rstmid_we", 32'(mem_we), 32'd0);
        chk_stalls("rstmid_after", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        mem_ack = 1'b1;
        @(negedge clk);
        chk("stray_req", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("stray_after_req", 32'(mem_req), 32'd0);
        chk("stray_after_addr", mem_addr, 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
